// File: rtl/dut_sched_pkg.sv
// Shared types and constants for the ALU scheduler: FSM states, opcode
// encodings and the latched ALU request bundle.
package dut_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_MUL = 1'b0;

  typedef struct packed {
    logic [7:0] data_A;
    logic [7:0] data_B;
    logic       sel_op;
  } alu_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after the pointer, wrapping from N-1 back to 0. Produces a one-hot grant and
// its encoded index; both are zero when no request is asserted.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int          pos;
  logic [IW-1:0] idx;
  logic        found;

  // Walk the requests starting at the pointer and keep the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr) + i;
      if (pos >= N) begin
        pos = pos - N;
      end
      idx = IW'(pos);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/dut_alu_scheduler.sv
// Shares one registered 8x8 add/multiply ALU between NUM_REQ requesters.
// Each operation runs accept -> issue -> wait -> capture -> respond with a
// single op in flight; the round-robin pointer moves past the served
// requester only once its response has been taken.
module dut_alu_scheduler
  import dut_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ*8-1:0] i_req_data_A,
  input  logic [NUM_REQ*8-1:0] i_req_data_B,
  input  logic [NUM_REQ-1:0]   i_req_sel_op,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_alu_data_A,
  output logic [7:0]           o_alu_data_B,
  output logic                 o_alu_sel_op,
  input  logic [15:0]          i_alu_data,
  output logic                 o_rsp_valid,
  output logic [ID_W-1:0]      o_rsp_id,
  output logic [15:0]          o_rsp_data,
  input  logic                 i_rsp_ready,
  output logic                 o_busy
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_e            state_q;
  state_e            state_d;
  alu_req_t          op_q;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       rsp_data_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               accept;
  logic               capture;
  logic               handshake;

  logic [7:0] req_a [NUM_REQ];
  logic [7:0] req_b [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_a[k] = i_req_data_A[8*k +: 8];
    assign req_b[k] = i_req_data_B[8*k +: 8];
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (i_req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // State register; reset aborts any op in flight without a response.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus every FSM-driven output; the ALU bus is zero outside ISSUE/WAIT.
  always_comb begin
    state_d      = state_q;
    o_req_ready  = '0;
    o_alu_data_A = '0;
    o_alu_data_B = '0;
    o_alu_sel_op = 1'b0;
    o_rsp_valid  = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    handshake    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|i_req_valid) begin
          accept      = 1'b1;
          o_req_ready = grant;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        o_alu_data_A = op_q.data_A;
        o_alu_data_B = op_q.data_B;
        o_alu_sel_op = op_q.sel_op;
        state_d      = WAIT;
      end
      WAIT: begin
        o_alu_data_A = op_q.data_A;
        o_alu_data_B = op_q.data_B;
        o_alu_sel_op = op_q.sel_op;
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sample the winner's operands and id only in the accept cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      op_q <= '0;
      id_q <= '0;
    end else if (accept) begin
      op_q.data_A <= req_a[grant_idx];
      op_q.data_B <= req_b[grant_idx];
      op_q.sel_op <= i_req_sel_op[grant_idx];
      id_q        <= grant_idx;
    end
  end

  // Count down the ALU latency; loaded on issue so capture lands ALU_LAT cycles later.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      cnt_q <= CNT_W'(ALU_LAT - 1);
    end else if (state_q == WAIT && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Capture the ALU result once the wait count expires and hold it through RESP.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rsp_data_q <= '0;
    end else if (capture) begin
      rsp_data_q <= i_alu_data;
    end
  end

  // Move the round-robin pointer past the served requester on response handshake.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ptr_q <= '0;
    end else if (handshake) begin
      ptr_q <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
    end
  end

  assign o_rsp_id   = id_q;
  assign o_rsp_data = rsp_data_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dut_alu_scheduler.sv
// Self-checking bench for dut_alu_scheduler: directed scenarios plus a
// randomized run checked against a transaction-level round-robin model.
module tb_dut_alu_scheduler;
  import dut_sched_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data_A;
  logic [31:0] req_data_B;
  logic [3:0]  req_sel_op;
  logic [3:0]  req_ready;
  logic [7:0]  alu_A;
  logic [7:0]  alu_B;
  logic        alu_op;
  logic [15:0] alu_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_ready;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int model_ptr = 0;

  dut_alu_scheduler #(.NUM_REQ(4), .ALU_LAT(1)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .i_req_data_A (req_data_A),
    .i_req_data_B (req_data_B),
    .i_req_sel_op (req_sel_op),
    .o_req_ready  (req_ready),
    .o_alu_data_A (alu_A),
    .o_alu_data_B (alu_B),
    .o_alu_sel_op (alu_op),
    .i_alu_data   (alu_data),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_id     (rsp_id),
    .o_rsp_data   (rsp_data),
    .i_rsp_ready  (rsp_ready),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model with one registered cycle of latency.
  always @(posedge clk) begin
    alu_data <= alu_op ? ({8'd0, alu_A} + {8'd0, alu_B}) : ({8'd0, alu_A} * {8'd0, alu_B});
  end

  // Expected arithmetic straight from the operand values.
  function automatic logic [15:0] alu_ref(logic [7:0] a, logic [7:0] b, logic op);
    int r;
    r = op ? (int'(a) + int'(b)) : (int'(a) * int'(b));
    return r[15:0];
  endfunction

  // Round-robin rule: build the service order from the pointer, pick the first valid.
  function automatic int exp_grant(logic [3:0] v, int ptr);
    int order[$];
    for (int i = ptr; i < 4; i++) order.push_back(i);
    for (int i = 0; i < ptr; i++) order.push_back(i);
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic logic [3:0] onehot_of(int g);
    logic [3:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(int k, logic [7:0] a, logic [7:0] b, logic op);
    req_data_A[k*8 +: 8] = a;
    req_data_B[k*8 +: 8] = b;
    req_sel_op[k]        = op;
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    req_valid  = '0;
    req_data_A = '0;
    req_data_B = '0;
    req_sel_op = '0;
    rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    model_ptr = 0;
  endtask

  // Advance until an accept strobe is seen at the sample point, bounded.
  task automatic wait_accept(output int idx, output bit ok);
    ok  = 1'b0;
    idx = -1;
    for (int c = 0; c < 50; c++) begin
      settle();
      if (req_ready != '0) begin
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (req_ready[i]) idx = i;
        break;
      end
      tick();
    end
  endtask

  // Advance until o_rsp_valid is seen; cyc counts sample points waited.
  task automatic wait_rsp(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int c = 0; c < 50; c++) begin
      settle();
      if (rsp_valid) begin
        ok  = 1'b1;
        cyc = c;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req_valid  = '0;
    req_data_A = '0;
    req_data_B = '0;
    req_sel_op = '0;
    rsp_ready  = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, alu_A, alu_B, alu_op, rsp_valid, rsp_id, rsp_data, busy} !== '0) begin
      $display("[TB] FAIL reset_outputs: got rdy=%b alu=%h/%h/%b rsp=%b/%0d/%h busy=%b expected all 0",
               req_ready, alu_A, alu_B, alu_op, rsp_valid, rsp_id, rsp_data, busy);
    end else n_pass++;
    apply_reset();
    settle();
    n_checks++;
    if ({req_ready, rsp_valid, busy} !== '0) begin
      $display("[TB] FAIL idle_after_reset: got rdy=%b rsp_valid=%b busy=%b expected 0", req_ready, rsp_valid, busy);
    end else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    int idx; int cyc; bit ok; bit seen;
    rsp_ready = 1'b1;
    set_req(0, 8'd3, 8'd4, OP_ADD);
    req_valid = 4'b0001;
    wait_accept(idx, ok);
    tick();
    req_valid = '0;
    tick();
    settle();
    n_checks++;
    if (!(ok && busy === 1'b1 && alu_A === 8'd3 && alu_B === 8'd4)) begin
      $display("[TB] FAIL midwait_setup: got ok=%b busy=%b alu=%h/%h expected busy with 03/04", ok, busy, alu_A, alu_B);
    end else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, alu_A, alu_B, alu_op, rsp_valid, rsp_id, rsp_data, busy} !== '0) begin
      $display("[TB] FAIL midwait_reset_outputs: got rdy=%b alu=%h/%h/%b rsp=%b/%0d/%h busy=%b expected all 0",
               req_ready, alu_A, alu_B, alu_op, rsp_valid, rsp_id, rsp_data, busy);
    end else n_pass++;
    tick();
    tick();
    reset     = 1'b0;
    model_ptr = 0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (rsp_valid || busy) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin
      $display("[TB] FAIL midwait_no_response: got activity=%b expected 0", seen);
    end else n_pass++;
    for (int k = 1; k < 4; k++) set_req(k, 8'(k), 8'(k), OP_ADD);
    req_valid = 4'b1111;
    wait_accept(idx, ok);
    n_checks++;
    if (!ok || idx != exp_grant(4'b1111, model_ptr)) begin
      $display("[TB] FAIL midwait_regrant: got %0d expected %0d", idx, exp_grant(4'b1111, model_ptr));
    end else n_pass++;
    tick();
    req_valid = '0;
    wait_rsp(cyc, ok);
    n_checks++;
    if (!ok || rsp_id !== 2'd0 || rsp_data !== alu_ref(8'd3, 8'd4, OP_ADD)) begin
      $display("[TB] FAIL midwait_rerun_rsp: got id=%0d data=%h expected id=0 data=%h", rsp_id, rsp_data, alu_ref(8'd3, 8'd4, OP_ADD));
    end else n_pass++;
    tick();
    model_ptr = 1;
  endtask

  task automatic test_single_mul();
    int idx; int cyc; bit ok;
    rsp_ready = 1'b1;
    set_req(1, 8'd12, 8'd11, OP_MUL);
    req_valid = 4'b0010;
    wait_accept(idx, ok);
    n_checks++;
    if (!ok || req_ready !== 4'b0010) begin
      $display("[TB] FAIL single_accept: got rdy=%b expected 0010", req_ready);
    end else n_pass++;
    tick();
    req_valid = '0;
    wait_rsp(cyc, ok);
    n_checks++;
    if (!ok || cyc + 1 != 3) begin
      $display("[TB] FAIL single_latency: got %0d cycles expected 3", cyc + 1);
    end else n_pass++;
    n_checks++;
    if (rsp_id !== 2'd1 || rsp_data !== 16'd132) begin
      $display("[TB] FAIL single_rsp: got id=%0d data=%0d expected id=1 data=132", rsp_id, rsp_data);
    end else n_pass++;
    tick();
    model_ptr = 2;
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$]; int ids[$]; logic [15:0] datas[$];
    int g; int p; logic [3:0] prev_rdy;
    apply_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) set_req(k, 8'(k), 8'(k + 1), OP_ADD);
    req_valid = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      settle();
      if (req_ready != '0) acc_cyc.push_back(c);
      if (rsp_valid && rsp_ready) begin
        ids.push_back(int'(rsp_id));
        datas.push_back(rsp_data);
        if (ids.size() == 5) begin
          req_valid = '0;
          tick();
          break;
        end
      end
      tick();
    end
    n_checks++;
    if (ids.size() != 5 || acc_cyc.size() < 5) begin
      $display("[TB] FAIL b2b_count: got %0d responses %0d accepts expected 5/5", ids.size(), acc_cyc.size());
    end else n_pass++;
    p = 0;
    for (int j = 0; j < ids.size(); j++) begin
      g = exp_grant(4'b1111, p);
      n_checks++;
      if (ids[j] != g || datas[j] !== alu_ref(8'(g), 8'(g + 1), OP_ADD)) begin
        $display("[TB] FAIL b2b_rsp%0d: got id=%0d data=%0d expected id=%0d data=%0d",
                 j, ids[j], datas[j], g, alu_ref(8'(g), 8'(g + 1), OP_ADD));
      end else n_pass++;
      p = (g + 1) % 4;
    end
    for (int j = 1; j < acc_cyc.size() && j < 5; j++) begin
      n_checks++;
      if (acc_cyc[j] - acc_cyc[j-1] != 4) begin
        $display("[TB] FAIL b2b_gap%0d: got %0d cycles expected 4", j, acc_cyc[j] - acc_cyc[j-1]);
      end else n_pass++;
    end
    prev_rdy = req_ready;
    model_ptr = p;
    settle();
    n_checks++;
    if (busy !== 1'b0) begin
      $display("[TB] FAIL b2b_drain: got busy=%b rdy=%b expected idle", busy, prev_rdy);
    end else n_pass++;
  endtask

  task automatic test_boundary_arith();
    int idx; int cyc; bit ok;
    rsp_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      set_req(2, 8'd255, 8'd255, (t == 0) ? OP_MUL : OP_ADD);
      req_valid = 4'b0100;
      wait_accept(idx, ok);
      tick();
      req_valid = '0;
      wait_rsp(cyc, ok);
      n_checks++;
      if (!ok || idx != 2 || rsp_id !== 2'd2 || rsp_data !== ((t == 0) ? 16'hFE01 : 16'h01FE)) begin
        $display("[TB] FAIL arith_255_%0d: got id=%0d data=%h expected id=2 data=%h",
                 t, rsp_id, rsp_data, (t == 0) ? 16'hFE01 : 16'h01FE);
      end else n_pass++;
      tick();
      model_ptr = 3;
    end
  endtask

  task automatic test_stall();
    int idx; int cyc; bit ok; int g;
    logic [1:0] id0; logic [15:0] data0;
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) set_req(k, 8'(k + 10), 8'd3, OP_MUL);
    req_valid = 4'b1111;
    wait_accept(idx, ok);
    g = exp_grant(4'b1111, model_ptr);
    n_checks++;
    if (!ok || idx != g) begin
      $display("[TB] FAIL stall_grant: got %0d expected %0d", idx, g);
    end else n_pass++;
    tick();
    wait_rsp(cyc, ok);
    id0 = rsp_id;
    data0 = rsp_data;
    n_checks++;
    if (!ok || int'(id0) != g || data0 !== alu_ref(8'(g + 10), 8'd3, OP_MUL)) begin
      $display("[TB] FAIL stall_rsp: got id=%0d data=%0d expected id=%0d data=%0d", id0, data0, g, alu_ref(8'(g + 10), 8'd3, OP_MUL));
    end else n_pass++;
    for (int c = 0; c < 10; c++) begin
      tick();
      settle();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== id0 || rsp_data !== data0 || req_ready !== 4'b0000) begin
        $display("[TB] FAIL stall_hold%0d: got v=%b id=%0d data=%h rdy=%b expected v=1 id=%0d data=%h rdy=0000",
                 c, rsp_valid, rsp_id, rsp_data, req_ready, id0, data0);
      end else n_pass++;
    end
    rsp_ready = 1'b1;
    tick();
    model_ptr = (g + 1) % 4;
    settle();
    g = exp_grant(4'b1111, model_ptr);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== onehot_of(g)) begin
      $display("[TB] FAIL stall_next_grant: got v=%b rdy=%b expected v=0 rdy=%b", rsp_valid, req_ready, onehot_of(g));
    end else n_pass++;
    tick();
    req_valid = '0;
    wait_rsp(cyc, ok);
    n_checks++;
    if (!ok || int'(rsp_id) != g) begin
      $display("[TB] FAIL stall_after_rsp: got id=%0d expected %0d", rsp_id, g);
    end else n_pass++;
    tick();
    model_ptr = (g + 1) % 4;
  endtask

  task automatic test_operand_sampling();
    int idx; int cyc; bit ok;
    rsp_ready = 1'b1;
    set_req(3, 8'd20, 8'd30, OP_ADD);
    req_valid = 4'b1000;
    wait_accept(idx, ok);
    tick();
    req_valid = '0;
    set_req(3, 8'd99, 8'd99, OP_MUL);
    settle();
    n_checks++;
    if (alu_A !== 8'd20 || alu_B !== 8'd30 || alu_op !== OP_ADD) begin
      $display("[TB] FAIL sample_issue: got alu=%0d/%0d/%b expected 20/30/1", alu_A, alu_B, alu_op);
    end else n_pass++;
    wait_rsp(cyc, ok);
    n_checks++;
    if (!ok || rsp_id !== 2'd3 || rsp_data !== 16'd50) begin
      $display("[TB] FAIL sample_rsp: got id=%0d data=%0d expected id=3 data=50", rsp_id, rsp_data);
    end else n_pass++;
    tick();
    model_ptr = 0;
  endtask

  task automatic test_random();
    bit outstanding; int exp_id; logic [15:0] exp_data; int g; int n_rsp;
    outstanding = 1'b0;
    exp_id = 0;
    exp_data = '0;
    n_rsp = 0;
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        req_valid  = 4'($urandom_range(0, 15));
        req_data_A = $urandom;
        req_data_B = $urandom;
        req_sel_op = 4'($urandom_range(0, 15));
        rsp_ready  = ($urandom_range(0, 3) != 0);
      end else begin
        req_valid = '0;
        rsp_ready = 1'b1;
      end
      settle();
      if (req_ready != '0) begin
        g = exp_grant(req_valid, model_ptr);
        n_checks++;
        if (outstanding || req_ready !== onehot_of(g)) begin
          $display("[TB] FAIL rand_accept c%0d: got rdy=%b outstanding=%b expected rdy=%b",
                   c, req_ready, outstanding, onehot_of(g));
        end else n_pass++;
        if (g >= 0) begin
          exp_id   = g;
          exp_data = alu_ref(req_data_A[g*8 +: 8], req_data_B[g*8 +: 8], req_sel_op[g]);
        end
        outstanding = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        n_checks++;
        if (!outstanding || int'(rsp_id) != exp_id || rsp_data !== exp_data) begin
          $display("[TB] FAIL rand_rsp c%0d: got id=%0d data=%h expected id=%0d data=%h",
                   c, rsp_id, rsp_data, exp_id, exp_data);
        end else n_pass++;
        model_ptr   = (exp_id + 1) % 4;
        outstanding = 1'b0;
        n_rsp++;
      end
      tick();
    end
    n_checks++;
    if (n_rsp < 20 || outstanding) begin
      $display("[TB] FAIL rand_progress: got %0d responses outstanding=%b expected >=20 and 0", n_rsp, outstanding);
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_single_mul();
    test_back_to_back();
    test_boundary_arith();
    test_stall();
    test_operand_sampling();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
